spidergon_packetizer: RTL and testbench

//  CPU-side injection interface of one spidergon node. Takes a packet command (dest, VC, length)

---
 rtl/spidergon_packetizer.sv | 206 ++++++++++++++++++++
 tb/tb_spidergon_packetizer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spidergon_packetizer.sv
// spidergon_packetizer: CPU-side injection front end of one spidergon node.
// Turns a packet command plus a payload word stream into typed flits
// (HEADER/HEAD/BODY/TAIL) for the node's local injection port. It honours the
// node's per-VC head readiness and its ON/OFF vc_full flow control.
//
// Handshakes: a command transfers when cmd_valid && cmd_ready. A payload word
// transfers when pld_valid && pld_ready. A flit transfers ("fires") when
// flit_out_valid is high, the packet's VC is not full and, for head-type
// flits only, the node reports ready on that VC. While flit_out_valid is high
// and the flit has not fired, flit_out holds steady.
module spidergon_packetizer #(
    parameter int NUM_OF_NODES            = 8,
    parameter int FLIT_DATA_WIDTH         = 16,
    parameter int NUM_OF_VIRTUAL_CHANNELS = 2,
    parameter int MAX_PKT_WORDS           = 4,
    parameter int NODE_IDENTIFIER         = 0,
    localparam int DEST_NODE_WIDTH  = $clog2(NUM_OF_NODES),
    localparam int FLIT_TOTAL_WIDTH = 2 + FLIT_DATA_WIDTH,
    localparam int VC_WIDTH         = (NUM_OF_VIRTUAL_CHANNELS > 1) ? $clog2(NUM_OF_VIRTUAL_CHANNELS) : 1,
    localparam int LEN_WIDTH        = $clog2(MAX_PKT_WORDS + 1)
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [DEST_NODE_WIDTH-1:0]         cmd_dest,
    input  logic [VC_WIDTH-1:0]                cmd_vc,
    input  logic [LEN_WIDTH-1:0]               cmd_len,
    input  logic                               pld_valid,
    output logic                               pld_ready,
    input  logic [FLIT_DATA_WIDTH-1:0]         pld_data,
    output logic [FLIT_TOTAL_WIDTH-1:0]        flit_out,
    output logic                               flit_out_valid,
    input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] node_is_ready,
    input  logic [NUM_OF_VIRTUAL_CHANNELS-1:0] node_vc_full,
    output logic                               busy,
    output logic                               pkt_sent,
    output logic                               err_bad_cmd,
    output logic [1:0]                         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEAD    = 2'd1,
        S_PAYLOAD = 2'd2,
        S_DROP    = 2'd3
    } state_e;

    localparam logic [1:0] T_HEADER = 2'b11;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_BODY   = 2'b10;
    localparam logic [1:0] T_TAIL   = 2'b00;

    localparam logic [DEST_NODE_WIDTH-1:0] SRC_ID   = DEST_NODE_WIDTH'(NODE_IDENTIFIER);
    localparam logic [LEN_WIDTH-1:0]       LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]       LEN_MAX  = LEN_WIDTH'(MAX_PKT_WORDS);

    state_e                        state_q, state_d;
    logic [FLIT_TOTAL_WIDTH-1:0]   flit_q, flit_d;
    logic                          flit_valid_q, flit_valid_d;
    logic [VC_WIDTH-1:0]           cur_vc_q, cur_vc_d;
    logic [LEN_WIDTH-1:0]          len_q, len_d;
    logic [LEN_WIDTH-1:0]          words_left_q, words_left_d;
    logic                          err_q, err_d;

    logic [FLIT_DATA_WIDTH-1:0]    head_data;
    logic                          dest_out_of_range;
    logic                          bad_cmd;
    logic                          flit_is_head;
    logic                          flit_is_last;
    logic                          fire;
    logic                          reload;

    // Destinations past the ring end are only possible when the dest field has spare codes.
    if ((1 << DEST_NODE_WIDTH) > NUM_OF_NODES) begin : g_dest_range
        assign dest_out_of_range = (int'(cmd_dest) >= NUM_OF_NODES);
    end else begin : g_dest_full
        assign dest_out_of_range = 1'b0;
    end

    // Head/HEADER data field: vc, dest, source id, then zero padding.
    always_comb begin
        head_data = '0;
        head_data[FLIT_DATA_WIDTH-1 -: VC_WIDTH]                          = cmd_vc;
        head_data[FLIT_DATA_WIDTH-1-VC_WIDTH -: DEST_NODE_WIDTH]          = cmd_dest;
        head_data[FLIT_DATA_WIDTH-1-VC_WIDTH-DEST_NODE_WIDTH -: DEST_NODE_WIDTH] = SRC_ID;
    end

    assign bad_cmd = (cmd_len > LEN_MAX) || (cmd_dest == SRC_ID) || dest_out_of_range;

    // HEAD (01) and HEADER (11) share type bit 0; HEADER and TAIL end a packet.
    assign flit_is_head = flit_q[FLIT_TOTAL_WIDTH-2];
    assign flit_is_last = flit_q[FLIT_TOTAL_WIDTH-1] == flit_q[FLIT_TOTAL_WIDTH-2];
    assign fire   = flit_valid_q && !node_vc_full[cur_vc_q] && (!flit_is_head || node_is_ready[cur_vc_q]);
    assign reload = !flit_valid_q || fire;

    // Next-state, output-register reload and handshake strobes.
    always_comb begin
        state_d      = state_q;
        flit_d       = flit_q;
        flit_valid_d = flit_valid_q;
        cur_vc_d     = cur_vc_q;
        len_d        = len_q;
        words_left_d = words_left_q;
        err_d        = 1'b0;
        cmd_ready    = 1'b0;
        pld_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = reset;
                if (cmd_valid && reset) begin
                    if (bad_cmd) begin
                        err_d        = 1'b1;
                        words_left_d = cmd_len;
                        state_d      = (cmd_len == '0) ? S_IDLE : S_DROP;
                    end else begin
                        cur_vc_d     = cmd_vc;
                        len_d        = cmd_len;
                        flit_d       = {(cmd_len == '0) ? T_HEADER : T_HEAD, head_data};
                        flit_valid_d = 1'b1;
                        state_d      = S_HEAD;
                    end
                end
            end

            S_HEAD: begin
                if (fire) begin
                    if (len_q == '0) begin
                        flit_valid_d = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        // The head-fire cycle already takes the first word so flits stay back-to-back.
                        pld_ready = 1'b1;
                        state_d   = S_PAYLOAD;
                        if (pld_valid) begin
                            flit_d       = {(len_q == LEN_ONE) ? T_TAIL : T_BODY, pld_data};
                            flit_valid_d = 1'b1;
                            words_left_d = len_q - LEN_ONE;
                        end else begin
                            flit_valid_d = 1'b0;
                            words_left_d = len_q;
                        end
                    end
                end
            end

            S_PAYLOAD: begin
                if (fire && flit_is_last) begin
                    flit_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end else if (reload) begin
                    pld_ready = (words_left_q != '0);
                    if (pld_ready && pld_valid) begin
                        flit_d       = {(words_left_q == LEN_ONE) ? T_TAIL : T_BODY, pld_data};
                        flit_valid_d = 1'b1;
                        words_left_d = words_left_q - LEN_ONE;
                    end else begin
                        flit_valid_d = 1'b0;
                    end
                end
            end

            S_DROP: begin
                pld_ready = 1'b1;
                if (pld_valid) begin
                    words_left_d = words_left_q - LEN_ONE;
                    if (words_left_q == LEN_ONE) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
            cur_vc_q     <= '0;
            len_q        <= '0;
            words_left_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            flit_q       <= flit_d;
            flit_valid_q <= flit_valid_d;
            cur_vc_q     <= cur_vc_d;
            len_q        <= len_d;
            words_left_q <= words_left_d;
            err_q        <= err_d;
        end
    end

    assign flit_out       = flit_q;
    assign flit_out_valid = flit_valid_q;
    assign busy           = (state_q != S_IDLE);
    assign pkt_sent       = fire && flit_is_last;
    assign err_bad_cmd    = err_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_spidergon_packetizer.sv
// Directed bench for spidergon_packetizer (8 nodes, 16-bit data, 2 VCs, node 0).
module tb_spidergon_packetizer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_dest = '0;
    logic [0:0]  cmd_vc = '0;
    logic [2:0]  cmd_len = '0;
    logic        pld_valid = 1'b0;
    logic        pld_ready;
    logic [15:0] pld_data = '0;
    logic [17:0] flit_out;
    logic        flit_out_valid;
    logic [1:0]  node_is_ready = 2'b11;
    logic [1:0]  node_vc_full = 2'b00;
    logic        busy;
    logic        pkt_sent;
    logic        err_bad_cmd;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    spidergon_packetizer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dest(cmd_dest), .cmd_vc(cmd_vc), .cmd_len(cmd_len),
        .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
        .flit_out(flit_out), .flit_out_valid(flit_out_valid),
        .node_is_ready(node_is_ready), .node_vc_full(node_vc_full),
        .busy(busy), .pkt_sent(pkt_sent), .err_bad_cmd(err_bad_cmd),
        .dbg_state(dbg_state)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] dest, input logic [0:0] vc, input logic [2:0] len);
        cmd_dest  = dest;
        cmd_vc    = vc;
        cmd_len   = len;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (flit_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", flit_out_valid); end
        checks++; if (flit_out !== 18'h0) begin errors++; $display("FAIL rst_flit got=%h exp=00000", flit_out); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
        checks++; if ({pld_ready, busy, pkt_sent, err_bad_cmd} !== 4'b0000) begin errors++; $display("FAIL rst_flags got=%b exp=0000", {pld_ready, busy, pkt_sent, err_bad_cmd}); end
        #20;
        reset = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_cmd_ready got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_header_only();
        send_cmd(3'd5, 1'b1, 3'd0);
        #1;
        checks++; if (flit_out !== 18'h3D000 || flit_out_valid !== 1'b1) begin errors++; $display("FAIL hdr_flit got=%h/%b exp=3d000/1", flit_out, flit_out_valid); end
        checks++; if (pkt_sent !== 1'b1) begin errors++; $display("FAIL hdr_pkt_sent got=%b exp=1", pkt_sent); end
        checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL hdr_busy got=%b%b exp=01", cmd_ready, busy); end
        tick();
        checks++; if (flit_out_valid !== 1'b0 || busy !== 1'b0 || pkt_sent !== 1'b0) begin errors++; $display("FAIL hdr_done got=%b%b%b exp=000", flit_out_valid, busy, pkt_sent); end
    endtask

    task automatic test_stream();
        logic [17:0] exp_f [4];
        logic [15:0] words [3];
        exp_f[0] = 18'h12000; exp_f[1] = 18'h2AAAA; exp_f[2] = 18'h2BBBB; exp_f[3] = 18'h0CCCC;
        words[0] = 16'hAAAA; words[1] = 16'hBBBB; words[2] = 16'hCCCC;
        pld_valid = 1'b1;
        pld_data  = words[0];
        send_cmd(3'd2, 1'b0, 3'd3);
        for (int i = 0; i < 4; i++) begin
            pld_valid = (i < 3);
            if (i < 3) pld_data = words[i];
            #1;
            checks++; if (flit_out !== exp_f[i] || flit_out_valid !== 1'b1) begin errors++; $display("FAIL stream_flit%0d got=%h/%b exp=%h/1", i, flit_out, flit_out_valid, exp_f[i]); end
            checks++; if (pkt_sent !== (i == 3)) begin errors++; $display("FAIL stream_pkt_sent%0d got=%b exp=%b", i, pkt_sent, (i == 3)); end
            tick();
        end
        checks++; if (flit_out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stream_end got=%b%b exp=00", flit_out_valid, busy); end
    endtask

    task automatic test_vc_full();
        pld_valid = 1'b1;
        pld_data  = 16'hAAAA;
        send_cmd(3'd2, 1'b0, 3'd3);
        #1;
        checks++; if (flit_out !== 18'h12000) begin errors++; $display("FAIL full_head got=%h exp=12000", flit_out); end
        tick();
        pld_data = 16'hBBBB;
        for (int h = 0; h < 3; h++) begin
            node_vc_full = 2'b01;
            #1;
            checks++; if (flit_out !== 18'h2AAAA || flit_out_valid !== 1'b1) begin errors++; $display("FAIL full_hold%0d got=%h/%b exp=2aaaa/1", h, flit_out, flit_out_valid); end
            checks++; if (pld_ready !== 1'b0) begin errors++; $display("FAIL full_pld_ready%0d got=%b exp=0", h, pld_ready); end
            tick();
        end
        node_vc_full = 2'b00;
        #1;
        checks++; if (flit_out !== 18'h2AAAA || pld_ready !== 1'b1) begin errors++; $display("FAIL full_release got=%h/%b exp=2aaaa/1", flit_out, pld_ready); end
        tick();
        pld_data = 16'hCCCC;
        #1;
        checks++; if (flit_out !== 18'h2BBBB) begin errors++; $display("FAIL full_body2 got=%h exp=2bbbb", flit_out); end
        tick();
        pld_valid = 1'b0;
        #1;
        checks++; if (flit_out !== 18'h0CCCC || pkt_sent !== 1'b1) begin errors++; $display("FAIL full_tail got=%h/%b exp=0cccc/1", flit_out, pkt_sent); end
        tick();
        checks++; if (flit_out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL full_end got=%b%b exp=00", flit_out_valid, busy); end
    endtask

    task automatic test_head_wait();
        node_is_ready = 2'b01;
        pld_valid     = 1'b1;
        pld_data      = 16'h1234;
        send_cmd(3'd3, 1'b1, 3'd1);
        for (int h = 0; h < 5; h++) begin
            #1;
            checks++; if (flit_out !== 18'h1B000 || pld_ready !== 1'b0 || pkt_sent !== 1'b0) begin errors++; $display("FAIL wait_hold%0d got=%h/%b%b exp=1b000/00", h, flit_out, pld_ready, pkt_sent); end
            tick();
        end
        node_is_ready = 2'b11;
        #1;
        checks++; if (flit_out !== 18'h1B000 || pld_ready !== 1'b1) begin errors++; $display("FAIL wait_fire got=%h/%b exp=1b000/1", flit_out, pld_ready); end
        tick();
        // Tail must go out even though the head-ready line drops again.
        node_is_ready = 2'b01;
        pld_valid     = 1'b0;
        #1;
        checks++; if (flit_out !== 18'h01234 || pkt_sent !== 1'b1) begin errors++; $display("FAIL wait_tail got=%h/%b exp=01234/1", flit_out, pkt_sent); end
        tick();
        node_is_ready = 2'b11;
        checks++; if (flit_out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wait_end got=%b%b exp=00", flit_out_valid, busy); end
    endtask

    task automatic test_bad_cmd(input logic [2:0] dest, input logic [2:0] len);
        send_cmd(dest, 1'b0, len);
        pld_valid = 1'b1;
        pld_data  = 16'hDEAD;
        #1;
        checks++; if (err_bad_cmd !== 1'b1) begin errors++; $display("FAIL bad_err_len%0d got=%b exp=1", len, err_bad_cmd); end
        for (int w = 0; w < int'(len); w++) begin
            checks++; if (pld_ready !== 1'b1 || flit_out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bad_drop_len%0d_w%0d got=%b%b%b exp=101", len, w, pld_ready, flit_out_valid, busy); end
            tick();
            #1;
            if (w == 0) begin
                checks++; if (err_bad_cmd !== 1'b0) begin errors++; $display("FAIL bad_err_pulse_len%0d got=%b exp=0", len, err_bad_cmd); end
            end
        end
        pld_valid = 1'b0;
        checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1 || flit_out_valid !== 1'b0) begin errors++; $display("FAIL bad_end_len%0d got=%b%b%b exp=010", len, busy, cmd_ready, flit_out_valid); end
        tick();
    endtask

    task automatic test_mid_reset();
        pld_valid = 1'b1;
        pld_data  = 16'hAAAA;
        send_cmd(3'd2, 1'b0, 3'd3);
        tick();
        checks++; if (flit_out !== 18'h2AAAA) begin errors++; $display("FAIL mrst_body got=%h exp=2aaaa", flit_out); end
        reset = 1'b0;
        #1;
        checks++; if (flit_out_valid !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mrst_clear got=%b%b%b exp=000", flit_out_valid, cmd_ready, busy); end
        pld_valid = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready got=%b exp=1", cmd_ready); end
        send_cmd(3'd5, 1'b1, 3'd0);
        #1;
        checks++; if (flit_out !== 18'h3D000 || pkt_sent !== 1'b1) begin errors++; $display("FAIL mrst_new got=%h/%b exp=3d000/1", flit_out, pkt_sent); end
        tick();
    endtask

    // Scenario sequence and final report
    initial begin
        test_reset();
        test_header_only();
        test_stream();
        test_vc_full();
        test_head_wait();
        test_bad_cmd(3'd0, 3'd2);
        test_bad_cmd(3'd3, 3'd5);
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
